// File: rtl/toggle_pulse_decoder.sv
// Receive side of toggle signalling: synchronises a sender's T_FF level and turns
// each transition into a one-cycle pulse, with pending/ack, sticky overrun and a saturating count.
//
// state | meaning
// PRIME | after reset: sync chain filling, prev tracks level, no events decoded
// RUN   | edge = level ^ prev, events decoded every cycle
module toggle_pulse_decoder #(
    parameter int SYNC_STAGES = 2,
    parameter int CNT_WIDTH   = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 tog_in,
    input  logic                 ack,
    input  logic                 clr_cnt,
    input  logic                 clr_ovr,
    output logic                 pulse,
    output logic                 pending,
    output logic                 overrun,
    output logic                 level,
    output logic [CNT_WIDTH-1:0] evt_count
);

    localparam logic [0:0] ST_PRIME = 1'b0;
    localparam logic [0:0] ST_RUN   = 1'b1;

    localparam int                   PW         = $clog2(SYNC_STAGES + 1);
    localparam logic [PW-1:0]        PRIME_LOAD = PW'(SYNC_STAGES);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX    = '1;

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;
    logic [0:0]             state_q;
    logic [PW-1:0]          prime_cnt;
    logic                   tog_edge;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], tog_in};
        end
    end

    assign level    = sync_q[SYNC_STAGES-1];
    assign tog_edge = (state_q == ST_RUN) && (level ^ prev_q);

    // The sync chain restarts from 0 on reset, so PRIME stays until the chain has
    // refilled and prev has sampled the settled level; a level held at 1 through
    // reset then never reads as a transition.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_PRIME;
            prime_cnt <= PRIME_LOAD;
            prev_q    <= 1'b0;
        end else begin
            prev_q <= level;
            case (state_q)
                ST_PRIME: begin
                    if (prime_cnt == '0) begin
                        state_q <= ST_RUN;
                    end else begin
                        prime_cnt <= prime_cnt - PW'(1);
                    end
                end
                default: state_q <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pulse     <= 1'b0;
            pending   <= 1'b0;
            overrun   <= 1'b0;
            evt_count <= '0;
        end else begin
            pulse <= tog_edge;

            if (tog_edge) begin
                pending <= 1'b1;
            end else if (ack) begin
                pending <= 1'b0;
            end

            // A new overrun beats a simultaneous clear so the event is not lost.
            if (tog_edge && pending && !ack) begin
                overrun <= 1'b1;
            end else if (clr_ovr) begin
                overrun <= 1'b0;
            end

            if (clr_cnt) begin
                evt_count <= tog_edge ? CNT_WIDTH'(1) : '0;
            end else if (tog_edge && (evt_count != CNT_MAX)) begin
                evt_count <= evt_count + CNT_WIDTH'(1);
            end
        end
    end

endmodule
